// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between I-cache and D-cache.
// Optional ARB_RR_EN selects round-robin tie-break; default is D-side priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IBUSY = 2'd1,
        S_DBUSY = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_gnt_d;

    logic w_ic_req;
    logic w_dc_req;
    logic w_pick_d;
    logic w_start;
    logic w_done;

    assign w_ic_req = ic_read;
    assign w_dc_req = dc_read | dc_write;
    assign w_start  = (r_state == S_IDLE) & (w_ic_req | w_dc_req);
    assign w_done   = ((r_state == S_IBUSY) | (r_state == S_DBUSY)) & mem_ready;

`ifdef ARB_RR_EN
    // 1 = D-side was granted last; reset value means I-side last
    logic r_last_d;

    // tie goes to whichever side was not granted last
    assign w_pick_d = w_dc_req & (~w_ic_req | ~r_last_d);

    // remember the grantee of every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (w_start) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // fixed priority: D-side wins every tie
    assign w_pick_d = w_dc_req;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ic_req | w_dc_req) begin
                    w_next = w_pick_d ? S_DBUSY : S_IBUSY;
                end
            end
            S_IBUSY, S_DBUSY: begin
                if (mem_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // hold registers for the memory command and the returned line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_gnt_d     <= 1'b0;
        end else if (w_start) begin
            r_gnt_d <= w_pick_d;
            if (w_pick_d) begin
                // read+write together is illegal; issue the write only
                r_mem_read  <= dc_read & ~dc_write;
                r_mem_write <= dc_write;
                r_mem_addr  <= dc_addr;
                r_mem_wdata <= dc_wdata;
            end else begin
                r_mem_read  <= 1'b1;
                r_mem_write <= 1'b0;
                r_mem_addr  <= ic_addr;
            end
        end else if (w_done) begin
            r_rdata     <= mem_rdata;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ic_rdata  = r_rdata;
    assign dc_rdata  = r_rdata;
    assign ic_ready  = (r_state == S_RESP) & ~r_gnt_d;
    assign dc_ready  = (r_state == S_RESP) & r_gnt_d;
    assign arb_busy  = (r_state != S_IDLE);

endmodule
